// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one fixed-latency backing memory between
// instruction fetch and the data stage, one transaction at a time.
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int MEM_BYTES  = 1024,
   parameter int STARVE_MAX = 4
) (
   input  logic        clock,
   input  logic        resetting,
   // fetch port
   input  logic        if_req,
   input  logic [63:0] if_addr,
   input  logic        if_flush,
   output logic        if_ready,
   output logic        if_rvalid,
   output logic [63:0] if_rdata,
   output logic        if_error,
   // data port
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [63:0] dm_addr,
   input  logic [63:0] dm_wdata,
   output logic        dm_ready,
   output logic        dm_rvalid,
   output logic [63:0] dm_rdata,
   output logic        dm_error,
   // backing memory
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   output logic        busy
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);
   localparam int SW    = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic              owner_dm;     // 1 = data stage owns the current transaction
   logic              kill;
   logic [LAT_W-1:0]  lat_cnt;
   logic [SW-1:0]     starve;
   logic              grant_if, grant_dm, acc_err, capture;
   logic [63:0]       acc_addr;

   // Data wins unless fetch has already lost STARVE_MAX times in a row.
   always_comb begin
      grant_dm = (state == IDLE) && dm_req && !(if_req && starve == SW'(STARVE_MAX));
      grant_if = (state == IDLE) && if_req && !grant_dm;
      acc_addr = grant_dm ? dm_addr : if_addr;
      acc_err  = (acc_addr >= 64'(MEM_BYTES));
   end

   // WAIT spans the MEM_LAT cycles after the strobe; its last cycle samples mem_rdata.
   assign capture = (state == WAIT) && (lat_cnt == '0);

   always_ff @(posedge clock or negedge resetting) begin
      if (!resetting) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nxt = state;
      if_ready  = 1'b0;
      dm_ready  = 1'b0;
      if_rvalid = 1'b0;
      dm_rvalid = 1'b0;
      mem_en    = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            // Readies are gated by reset so every output reads 0 while it is held.
            if_ready = grant_if & resetting;
            dm_ready = grant_dm & resetting;
            if (grant_if || grant_dm) state_nxt = acc_err ? RESP : ISSUE;
         end
         ISSUE: begin
            mem_en    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (capture) state_nxt = RESP;
         RESP: begin
            // A flush in the response cycle itself still suppresses the fetch pulse.
            if_rvalid = !owner_dm && !kill && !if_flush;
            dm_rvalid = owner_dm;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetting) begin
      // NOTE: all state here uses non-blocking assignments and is async-reset to 0.
      if (!resetting) begin
         owner_dm  <= 1'b0;
         kill      <= 1'b0;
         lat_cnt   <= '0;
         starve    <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         if_error  <= 1'b0;
         dm_rdata  <= '0;
         dm_error  <= 1'b0;
      end else begin
         if (state == IDLE) begin
            if (!if_req || grant_if)                        starve <= '0;
            else if (grant_dm && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
         end

         if (grant_if || grant_dm) begin
            owner_dm  <= grant_dm;
            kill      <= 1'b0;
            mem_we    <= grant_dm & dm_we;
            mem_addr  <= acc_addr;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            if (acc_err) begin
               if (grant_dm) begin
                  dm_rdata <= '0;
                  dm_error <= 1'b1;
               end else begin
                  if_rdata <= '0;
                  if_error <= 1'b1;
               end
            end
         end

         if (state != IDLE && !owner_dm && if_flush) kill <= 1'b1;

         if (state == ISSUE)                         lat_cnt <= LAT_W'(MEM_LAT - 1);
         else if (state == WAIT && lat_cnt != '0)    lat_cnt <= lat_cnt - 1'b1;

         if (capture) begin
            if (owner_dm) begin
               dm_rdata <= mem_we ? '0 : mem_rdata;
               dm_error <= 1'b0;
            end else begin
               if_rdata <= mem_rdata;
               if_error <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level reference
// model that predicts grants, strobe and response cycles from the accept cycle.
module tb_mem_port_arbiter;

   localparam int MEM_LAT    = 2;
   localparam int MEM_BYTES  = 1024;
   localparam int STARVE_MAX = 4;

   logic        clock = 1'b0;
   logic        resetting = 1'b0;
   logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [63:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
   logic        if_ready, if_rvalid, if_error, dm_ready, dm_rvalid, dm_error;
   logic        mem_en, mem_we, busy;
   logic [63:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

   always #5 clock = ~clock;

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MEM_BYTES(MEM_BYTES), .STARVE_MAX(STARVE_MAX)) dut (
      .clock(clock), .resetting(resetting),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ready(if_ready),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_error(if_error),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_error(dm_error),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Physical backing memory (driven by the DUT strobe) and the model's own view.
   logic [63:0] bmem [32];
   logic [63:0] rmem [32];
   int          rd_cycle = -1;
   logic [63:0] rd_val = '0;

   // Transaction-level reference state.
   int          cyc = 0;
   int          free_at = 0;
   int          starve = 0;
   bit          act = 0;
   int          t_acc = 0;
   bit          o_dm = 0, t_we = 0, t_err = 0, t_kill = 0;
   logic [63:0] t_addr = '0, t_wdata = '0, t_exp = '0;

   function automatic logic [63:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return 64'd1024;
         1:       return 64'd1023;
         2:       return {32'hFFFF_FFFF, 32'($urandom)};
         default: return {56'd0, 8'($urandom)};
      endcase
   endfunction

   // One clock cycle: drive inputs, compare against the model, advance the model.
   task automatic step(input bit ifr, input logic [63:0] ia, input bit fl,
                       input bit dmr, input bit dwe, input logic [63:0] da,
                       input logic [63:0] dwd);
      bit idle, g_if, g_dm, exp_en, exp_ifv, exp_dmv;
      int resp_cyc;
      if_req = ifr; if_addr = ia; if_flush = fl;
      dm_req = dmr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
      mem_rdata = (cyc == rd_cycle) ? rd_val : {32'($urandom), 32'($urandom)};
      #2;
      idle     = (cyc >= free_at);
      g_dm     = idle && dmr && !(ifr && starve == STARVE_MAX);
      g_if     = idle && ifr && !g_dm;
      resp_cyc = !act ? -1 : (t_err ? t_acc + 1 : t_acc + MEM_LAT + 2);
      if (act && !o_dm && fl && cyc > t_acc && cyc <= resp_cyc) t_kill = 1;
      exp_en  = act && !t_err && (cyc == t_acc + 1);
      exp_ifv = act && !o_dm && (cyc == resp_cyc) && !t_kill;
      exp_dmv = act && o_dm && (cyc == resp_cyc);

      check("if_ready", if_ready, g_if);
      check("dm_ready", dm_ready, g_dm);
      check("mem_en", mem_en, exp_en);
      check("if_rvalid", if_rvalid, exp_ifv);
      check("dm_rvalid", dm_rvalid, exp_dmv);
      check("busy", busy, !idle);
      if (exp_en) begin
         check("mem_we", mem_we, t_we);
         check("mem_addr", mem_addr, t_addr);
         if (t_we) check("mem_wdata", mem_wdata, t_wdata);
      end
      if (exp_ifv) begin
         check("if_rdata", if_rdata, t_exp);
         check("if_error", if_error, t_err);
      end
      if (exp_dmv) begin
         check("dm_rdata", dm_rdata, t_exp);
         check("dm_error", dm_error, t_err);
      end

      // Backing memory responds to whatever the DUT actually strobes.
      if (mem_en) begin
         if (mem_we) bmem[mem_addr[7:3]] = mem_wdata;
         else begin
            rd_cycle = cyc + MEM_LAT;
            rd_val   = bmem[mem_addr[7:3]];
         end
      end

      if (act && cyc == resp_cyc) act = 0;
      if (idle) begin
         if (!ifr || g_if) starve = 0;
         else if (g_dm)    starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
      end
      if (g_if || g_dm) begin
         act     = 1;
         t_acc   = cyc;
         o_dm    = g_dm;
         t_we    = g_dm && dwe;
         t_addr  = g_dm ? da : ia;
         t_wdata = dwd;
         t_err   = (t_addr >= 64'(MEM_BYTES));
         t_kill  = 0;
         t_exp   = (t_err || t_we) ? 64'd0 : rmem[t_addr[7:3]];
         if (t_we && !t_err) rmem[t_addr[7:3]] = t_wdata;
         free_at = t_err ? cyc + 2 : cyc + MEM_LAT + 3;
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   // Asserts reset mid-cycle, checks every output is 0 at once, releases it so
   // the next rising edge is the first one in IDLE.
   task automatic do_reset(input int hold);
      #1 resetting = 1'b0;
      #1;
      check("rst_if_ready", if_ready, 0);
      check("rst_dm_ready", dm_ready, 0);
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_dm_rvalid", dm_rvalid, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_if_error", if_error, 0);
      check("rst_dm_rdata", dm_rdata, 0);
      check("rst_dm_error", dm_error, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_busy", busy, 0);
      repeat (hold) @(posedge clock);
      @(negedge clock);
      resetting = 1'b1;
      #1;
      act = 0; cyc = 0; free_at = 0; starve = 0; rd_cycle = -1;
      rmem = bmem;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         bmem[i] = {32'($urandom), 32'($urandom)};
         rmem[i] = bmem[i];
      end
      do_reset(2);

      // Fetch-only traffic, then a reset that lands inside a transaction.
      for (int i = 0; i < 30; i++)
         step(1, {56'd0, 8'($urandom)}, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++)
         step(1, 64'h10, 0, 0, 0, 0, 0);
      do_reset(1);

      // Both requesters always asserting: starvation pattern dm x4 then fetch.
      for (int i = 0; i < 60; i++)
         step(1, rand_addr(), 0, 1, 1'($urandom), rand_addr(), {32'($urandom), 32'($urandom)});

      // Fully random traffic with occasional flushes and asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if (i % 701 == 350) do_reset($urandom_range(0, 2));
         step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 7) == 0,
              $urandom_range(0, 1) == 1, 1'($urandom), rand_addr(),
              {32'($urandom), 32'($urandom)});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
